// File: rtl/uart_rx.sv
// uart_rx: asynchronous serial receiver, mid-bit sampling timed from the start edge.
// Optional UART_RX_MAJORITY_EN: 2-of-3 majority vote around each bit centre.
`ifndef FCLK
`define FCLK 12000000
`endif

module uart_rx #(
  parameter int Bauds = 1000000,
  parameter int Wdata = 8,
  parameter int Wstop = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             RXD,
  output logic [Wdata-1:0] DOUT,
  output logic             VALID,
  output logic             FERR,
  output logic             BUSY
);
  localparam int NT = `FCLK / Bauds;
  localparam int CW = $clog2(NT);
  localparam int IW = (Wdata > 1) ? $clog2(Wdata) : 1;
  localparam logic [CW-1:0] HALF = CW'(NT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(NT - 1);
  localparam logic [IW-1:0] LAST = IW'(Wdata - 1);
  localparam logic LSTP = 1'(Wstop - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, BREAK
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       sync_q;
  logic [1:0]       fill_q;
  logic             rxs;
  logic             armed_q, armed_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             stp_q, stp_d;
  logic             err_q, err_d;
  logic [Wdata-1:0] sh_q, sh_d;
  logic [Wdata-1:0] dout_d;
  logic             valid_d, ferr_d, busy_d;
  logic             tick, evt, samp, bad;

  assign rxs  = sync_q[1];
  assign tick = (cnt_q == '0);

`ifdef UART_RX_MAJORITY_EN
  logic s1_q, s0_q, pend_q, active;

  assign active = (state_q == START) || (state_q == DATA) ||
                  (state_q == STOP);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_q   <= 1'b1;
      s0_q   <= 1'b1;
      pend_q <= 1'b0;
    end else begin
      if (cnt_q == CW'(1)) s1_q <= rxs;
      if (tick) s0_q <= rxs;
      pend_q <= tick && active;
    end
  end

  // third vote is the live rxs in the cycle after the centre tick
  assign evt  = pend_q;
  assign samp = (s1_q & s0_q) | (s1_q & rxs) | (s0_q & rxs);
`else
  assign evt  = tick;
  assign samp = rxs;
`endif

  assign bad = err_q | ~samp;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stp_d   = stp_q;
    err_d   = err_q;
    sh_d    = sh_q;
    armed_d = armed_q;
    dout_d  = DOUT;
    ferr_d  = FERR;
    busy_d  = BUSY;
    valid_d = 1'b0;
    if (state_q == START || state_q == DATA || state_q == STOP)
      cnt_d = tick ? FULL : cnt_q - CW'(1);
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        // only arm once a genuine idle-high line has been seen
        if (fill_q[1] && rxs) armed_d = 1'b1;
        if (armed_q && !rxs) begin
          state_d = START;
          cnt_d   = HALF;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (evt) begin
          if (samp) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d = DATA;
            idx_d   = '0;
            err_d   = 1'b0;
          end
        end
      end
      DATA: begin
        if (evt) begin
          sh_d[idx_q] = samp;
          if (idx_q == LAST) begin
            state_d = STOP;
            stp_d   = 1'b0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      STOP: begin
        if (evt) begin
          err_d = bad;
          if (stp_q == LSTP) begin
            dout_d  = sh_q;
            ferr_d  = bad;
            valid_d = 1'b1;
            busy_d  = 1'b0;
            state_d = bad ? BREAK : IDLE;
          end else begin
            stp_d = 1'b1;
          end
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      sync_q  <= 2'b11;
      fill_q  <= 2'b00;
      armed_q <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
      stp_q   <= 1'b0;
      err_q   <= 1'b0;
      sh_q    <= '0;
      DOUT    <= '0;
      VALID   <= 1'b0;
      FERR    <= 1'b0;
      BUSY    <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], RXD};
      fill_q  <= {fill_q[0], 1'b1};
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stp_q   <= stp_d;
      err_q   <= err_d;
      sh_q    <= sh_d;
      DOUT    <= dout_d;
      VALID   <= valid_d;
      FERR    <= ferr_d;
      BUSY    <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames into uart_rx, scoreboard queue checked by a
// monitor on every VALID pulse.
`timescale 1ns/1ps

module tb_uart_rx;
  localparam int NT = 12;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       RXD = 1'b1;
  logic [7:0] DOUT;
  logic       VALID;
  logic       FERR;
  logic       BUSY;

  uart_rx #(
    .Bauds(1000000),
    .Wdata(8),
    .Wstop(1)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .RXD  (RXD),
    .DOUT (DOUT),
    .VALID(VALID),
    .FERR (FERR),
    .BUSY (BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0] d;
    logic       e;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   ncmp = 0;
  int   nbad = 0;
  logic pv = 1'b0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (RST_N && VALID) begin
      check("valid_1cyc", {31'b0, pv}, 0);
      if (q.size() == 0) begin
        check("unexpected_valid", {31'b0, VALID}, 0);
      end else begin
        me = q.pop_front();
        check("dout", {24'b0, DOUT}, {24'b0, me.d});
        check("ferr", {31'b0, FERR}, {31'b0, me.e});
        check("busy_at_valid", {31'b0, BUSY}, 0);
      end
    end
    pv = VALID;
  end

  task automatic bitp(logic v, int g = -1);
    for (int i = 0; i < NT; i++) begin
      @(negedge CLK);
      RXD = (i == g) ? ~v : v;
    end
  endtask

  task automatic send(logic [7:0] d, logic sv = 1'b1, int gb = -1);
    bitp(1'b0);
    for (int b = 0; b < 8; b++) bitp(d[b], (b == gb) ? 6 : -1);
    bitp(sv);
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge CLK);
      RXD = 1'b1;
    end
  endtask

  task automatic chk_rst(string nm);
    check({nm, "_dout"}, {24'b0, DOUT}, 0);
    check({nm, "_valid"}, {31'b0, VALID}, 0);
    check({nm, "_ferr"}, {31'b0, FERR}, 0);
    check({nm, "_busy"}, {31'b0, BUSY}, 0);
  endtask

  logic       seen;
  logic [7:0] d81;
  logic [7:0] g_exp;

  initial begin
    repeat (3) @(negedge CLK);
    chk_rst("rst");
    RST_N = 1'b1;
    idle(20);

    // 1: clean 0x55
    q.push_back('{d: 8'h55, e: 1'b0});
    send(8'h55);
    idle(24);
    check("busy_after_55", {31'b0, BUSY}, 0);

    // 2: short low glitch is a false start
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      RXD = 1'b0;
      if (BUSY) seen = 1'b1;
    end
    for (int i = 0; i < 24; i++) begin
      @(negedge CLK);
      RXD = 1'b1;
      if (BUSY) seen = 1'b1;
    end
    check("false_busy_seen", {31'b0, seen}, 1);
    check("false_busy_end", {31'b0, BUSY}, 0);
    check("false_dout_hold", {24'b0, DOUT}, 32'h55);

    // 3: framing error, held-low line, then recovery
    q.push_back('{d: 8'hA3, e: 1'b1});
    send(8'hA3, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      RXD = 1'b0;
      if (BUSY) seen = 1'b1;
    end
    check("break_no_busy", {31'b0, seen}, 0);
    idle(24);
    q.push_back('{d: 8'h3C, e: 1'b0});
    send(8'h3C);
    idle(24);

    // 4: back-to-back frames
    q.push_back('{d: 8'h00, e: 1'b0});
    q.push_back('{d: 8'hFF, e: 1'b0});
    send(8'h00);
    send(8'hFF);
    idle(24);

    // 5: reset during data bit 4 of 0x81
    d81 = 8'h81;
    bitp(1'b0);
    for (int b = 0; b < 4; b++) bitp(d81[b]);
    repeat (6) begin
      @(negedge CLK);
      RXD = d81[4];
    end
    RST_N = 1'b0;
    @(negedge CLK);
    RXD = d81[4];
    chk_rst("midrst");
    @(negedge CLK);
    RXD = d81[4];
    RST_N = 1'b1;
    repeat (4) begin
      @(negedge CLK);
      RXD = d81[4];
    end
    for (int b = 5; b < 8; b++) bitp(d81[b]);
    bitp(1'b1);
    idle(24);
    check("rst_no_busy", {31'b0, BUSY}, 0);
    check("rst_dout_zero", {24'b0, DOUT}, 0);
    q.push_back('{d: 8'h7E, e: 1'b0});
    send(8'h7E);
    idle(24);

    // 6: one-cycle glitch at the centre of bit 2
`ifdef UART_RX_MAJORITY_EN
    g_exp = 8'hF0;
`else
    g_exp = 8'hF4;
`endif
    q.push_back('{d: g_exp, e: 1'b0});
    send(8'hF0, 1'b1, 2);
    idle(24);

    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge CLK);
    check("drain", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
